// File: rtl/dual_rail_word_decoder.sv
// Receiving end of the dual-rail (T/F) word interface: return-to-spacer protocol, fault alarms, valid/ready output.
// Optional build macro INV_ROTWORD_EN: register the decoded word rotated right by one byte (inverse RotWord).
module dual_rail_word_decoder #(
  parameter int BYTE    = 8,
  parameter int WORD    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] Input_Word_T,
  input  logic [WORD-1:0] Input_Word_F,
  output logic [WORD-1:0] out_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            fault,
  output logic [1:0]      fault_code,
  input  logic            clear_fault
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    WAIT_SPACER,
    WAIT_DATA,
    HOLD,
    FAULT
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next, cnt_inc;
  logic [WORD-1:0] word_next, cap_word;
  logic            valid_next, fault_next;
  logic [1:0]      code_next;
  logic            all_spacer, complete, illegal;
  logic            timeout_hit, illegal_hit;

  // Per-bit pair classification: 00 spacer, 10/01 data, 11 illegal.
  assign all_spacer = ~|(Input_Word_T | Input_Word_F);
  assign complete   = &(Input_Word_T ^ Input_Word_F);
  assign illegal    = |(Input_Word_T & Input_Word_F);

  assign cnt_inc = (cnt == TMAX) ? cnt : cnt + CW'(1);

`ifdef INV_ROTWORD_EN
  assign cap_word = {Input_Word_T[BYTE-1:0], Input_Word_T[WORD-1:BYTE]};
`else
  assign cap_word = Input_Word_T;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_SPACER;
      cnt        <= '0;
      out_word   <= '0;
      out_valid  <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      out_word   <= word_next;
      out_valid  <= valid_next;
      fault      <= fault_next;
      fault_code <= code_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    word_next   = out_word;
    valid_next  = out_valid;
    fault_next  = fault;
    code_next   = fault_code;
    timeout_hit = 1'b0;
    illegal_hit = (state != FAULT) && illegal;

    // In the waiting states anything that is not forward progress (including illegal pairs) counts as a stall.
    case (state)
      WAIT_SPACER: begin
        if (all_spacer) begin
          state_next = WAIT_DATA;
          cnt_next   = '0;
        end else begin
          cnt_next    = cnt_inc;
          timeout_hit = (cnt_inc == TMAX);
        end
      end
      WAIT_DATA: begin
        if (all_spacer) begin
          cnt_next = '0;
        end else if (complete) begin
          word_next  = cap_word;
          valid_next = 1'b1;
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next    = cnt_inc;
          timeout_hit = (cnt_inc == TMAX);
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          valid_next = 1'b0;
          state_next = WAIT_SPACER;
          cnt_next   = '0;
        end
      end
      FAULT: begin
        valid_next = 1'b0;
        if (clear_fault) begin
          state_next = WAIT_SPACER;
          fault_next = 1'b0;
          code_next  = 2'b00;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = WAIT_SPACER;
        cnt_next   = '0;
      end
    endcase

    // A fault overrides any capture or handshake decided above; a held word is discarded.
    if (timeout_hit || illegal_hit) begin
      state_next = FAULT;
      fault_next = 1'b1;
      code_next  = {timeout_hit, illegal_hit};
      valid_next = 1'b0;
      cnt_next   = '0;
    end
  end

endmodule

// File: tb/tb_dual_rail_word_decoder.sv
// Self-checking bench for dual_rail_word_decoder: bit-counting behavioural model plus directed literal checks.
// Build with INV_ROTWORD_EN defined to check the rotated-word variant.
module tb_dual_rail_word_decoder;

  localparam int BYTE    = 8;
  localparam int WORD    = 32;
  localparam int TIMEOUT = 16;
  localparam int NB      = WORD / BYTE;

  logic            clk;
  logic            rst;
  logic [WORD-1:0] tRail, fRail;
  logic [WORD-1:0] out_word;
  logic            out_valid;
  logic            out_ready;
  logic            fault;
  logic [1:0]      fault_code;
  logic            clear_fault;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  // Model of the receiver's observable behaviour.
  int              mPhase;
  int              mStall;
  logic [WORD-1:0] mWord;
  logic            mValid;
  logic            mFault;
  logic [1:0]      mCode;

  dual_rail_word_decoder #(.BYTE(BYTE), .WORD(WORD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .Input_Word_T(tRail),
    .Input_Word_F(fRail),
    .out_word(out_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fault(fault),
    .fault_code(fault_code),
    .clear_fault(clear_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WORD-1:0] expectWord(input logic [WORD-1:0] d);
    logic [WORD-1:0] r;
    r = d;
`ifdef INV_ROTWORD_EN
    for (int j = 0; j < NB; j++) r[j*BYTE +: BYTE] = d[((j + 1) % NB)*BYTE +: BYTE];
`endif
    return r;
  endfunction

  // Phases: 0 waiting for spacer, 1 waiting for data, 2 holding a word, 3 faulted.
  always @(posedge clk) begin
    int nSp, nOk, nBad;
    bit bad, to;
    nSp = 0; nOk = 0; nBad = 0;
    for (int i = 0; i < WORD; i++) begin
      if (!tRail[i] && !fRail[i]) nSp++;
      else if (tRail[i] && fRail[i]) nBad++;
      else nOk++;
    end
    if (rst) begin
      mPhase = 0; mStall = 0; mWord = '0; mValid = 0; mFault = 0; mCode = 2'b00;
    end else if (mPhase == 3) begin
      if (clear_fault) begin
        mPhase = 0; mFault = 0; mCode = 2'b00; mStall = 0;
      end
    end else begin
      bad = (nBad > 0);
      to  = 0;
      if (mPhase == 0) begin
        if (nSp == WORD) begin mPhase = 1; mStall = 0; end
        else begin mStall++; to = (mStall >= TIMEOUT); end
      end else if (mPhase == 1) begin
        if (nSp == WORD) mStall = 0;
        else if (nOk == WORD) begin
          mWord = expectWord(tRail); mValid = 1; mPhase = 2; mStall = 0;
        end else begin mStall++; to = (mStall >= TIMEOUT); end
      end else begin
        if (mValid && out_ready) begin mValid = 0; mPhase = 0; mStall = 0; end
      end
      if (bad || to) begin
        mPhase = 3; mFault = 1; mCode = {to, bad}; mValid = 0; mStall = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_valid", WORD'(out_valid), WORD'(mValid));
      checkOutput("model_word", out_word, mWord);
      checkOutput("model_fault", WORD'(fault), WORD'(mFault));
      checkOutput("model_code", WORD'(fault_code), WORD'(mCode));
    end
  end

  task automatic applyStimulus(input logic [WORD-1:0] t, input logic [WORD-1:0] f,
                               input logic rdy, input logic clr, input logic r);
    tRail = t; fRail = f; out_ready = rdy; clear_fault = clr; rst = r;
    @(posedge clk);
    #1;
  endtask

  localparam logic [WORD-1:0] PT = 32'h0000FFFF;
  localparam logic [WORD-1:0] PF = 32'h00FF0000;

  initial begin
    logic [WORD-1:0] w1Exp, w2Exp;
`ifdef INV_ROTWORD_EN
    w1Exp = 32'h67012345;
    w2Exp = 32'h78123456;
`else
    w1Exp = 32'h01234567;
    w2Exp = 32'h12345678;
`endif
    tRail = '0; fRail = '0; out_ready = 0; clear_fault = 0; rst = 1;

    applyStimulus('0, '0, 0, 0, 1);
    applyStimulus('0, '0, 0, 0, 1);
    checkEn = 1'b1;
    checkOutput("reset_valid", WORD'(out_valid), '0);
    checkOutput("reset_word", out_word, '0);
    checkOutput("reset_fault", WORD'(fault), '0);
    checkOutput("reset_code", WORD'(fault_code), '0);

    applyStimulus('0, '0, 0, 0, 0);
    applyStimulus(32'h01234567, 32'hFEDCBA98, 0, 0, 0);
    checkOutput("first_valid", WORD'(out_valid), 1);
    checkOutput("first_word", out_word, w1Exp);
    checkOutput("first_fault", WORD'(fault), '0);

    repeat (5) applyStimulus(32'h01234567, 32'hFEDCBA98, 0, 0, 0);
    checkOutput("hold_valid", WORD'(out_valid), 1);
    checkOutput("hold_word", out_word, w1Exp);

    applyStimulus(32'h01234567, 32'hFEDCBA98, 1, 0, 0);
    checkOutput("handshake_drop", WORD'(out_valid), '0);

    repeat (3) applyStimulus(32'hA5A5A5A5, 32'h5A5A5A5A, 1, 0, 0);
    checkOutput("no_capture_without_spacer", WORD'(out_valid), '0);
    applyStimulus('0, '0, 0, 0, 0);
    applyStimulus(32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0, 0);
    checkOutput("capture_after_spacer", WORD'(out_valid), 1);

    applyStimulus('0, '0, 1, 0, 0);
    applyStimulus('0, '0, 0, 0, 0);
    applyStimulus(32'h00000080, 32'h00000080, 0, 0, 0);
    checkOutput("illegal_fault", WORD'(fault), 1);
    checkOutput("illegal_code", WORD'(fault_code), 32'd1);
    checkOutput("illegal_valid", WORD'(out_valid), '0);
    repeat (2) applyStimulus(32'h00000080, 32'h00000080, 1, 0, 0);
    applyStimulus('0, '0, 0, 1, 0);
    checkOutput("clear_fault", WORD'(fault), '0);
    checkOutput("clear_code", WORD'(fault_code), '0);

    applyStimulus('0, '0, 0, 0, 0);
    repeat (TIMEOUT - 1) applyStimulus(PT, PF, 0, 0, 0);
    checkOutput("stall15_no_fault", WORD'(fault), '0);
    applyStimulus(PT, PF, 0, 0, 0);
    checkOutput("timeout_fault", WORD'(fault), 1);
    checkOutput("timeout_code", WORD'(fault_code), 32'd2);
    applyStimulus('0, '0, 0, 1, 0);

    applyStimulus('0, '0, 0, 0, 0);
    repeat (TIMEOUT - 1) applyStimulus(PT, PF, 0, 0, 0);
    applyStimulus(32'h12345678, 32'hEDCBA987, 0, 0, 0);
    checkOutput("late_complete_valid", WORD'(out_valid), 1);
    checkOutput("late_complete_word", out_word, w2Exp);
    checkOutput("late_complete_fault", WORD'(fault), '0);
    applyStimulus('0, '0, 0, 0, 0);
    applyStimulus('0, '0, 0, 0, 1);
    checkOutput("rst_hold_valid", WORD'(out_valid), '0);
    checkOutput("rst_hold_word", out_word, '0);
    checkOutput("rst_hold_code", WORD'(fault_code), '0);

    applyStimulus('0, '0, 0, 0, 0);
    repeat (TIMEOUT - 1) applyStimulus(PT, PF, 0, 0, 0);
    applyStimulus(PT | 32'h80000000, PF | 32'h80000000, 0, 0, 0);
    checkOutput("both_code", WORD'(fault_code), 32'd3);
    applyStimulus('0, '0, 0, 1, 0);

    applyStimulus('0, '0, 0, 0, 0);
    applyStimulus(32'h01234567, 32'hFEDCBA98, 0, 0, 0);
    applyStimulus(32'h00000080, 32'h00000080, 1, 0, 0);
    checkOutput("hs_illegal_code", WORD'(fault_code), 32'd1);
    checkOutput("hs_illegal_valid", WORD'(out_valid), '0);
    applyStimulus('0, '0, 0, 1, 0);

    repeat (TIMEOUT) applyStimulus(PT, PF, 0, 0, 0);
    checkOutput("spacer_timeout_code", WORD'(fault_code), 32'd2);
    applyStimulus('0, '0, 0, 1, 0);
    applyStimulus('0, '0, 0, 1, 0);
    checkOutput("clear_outside_fault", WORD'(fault), '0);
    applyStimulus(32'hCAFEF00D, ~32'hCAFEF00D, 0, 1, 0);
    checkOutput("capture_with_clear_high", WORD'(out_valid), 1);
    applyStimulus('0, '0, 1, 0, 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
